// File: rtl/boron_pkg.sv
// Shared constants and helpers for the BORON encryption core.
package boron_pkg;

  localparam int unsigned NUM_ROUNDS = 25;
  localparam int unsigned KEY_ROT    = 13;
  localparam int unsigned ROT_W0     = 1;
  localparam int unsigned ROT_W1     = 4;
  localparam int unsigned ROT_W2     = 7;
  localparam int unsigned ROT_W3     = 9;

  // Source byte index for each destination byte, destination 0 in the low field.
  localparam logic [23:0] BYTE_SRC = {3'd5, 3'd4, 3'd7, 3'd6, 3'd1, 3'd0, 3'd3, 3'd2};

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hE;
      4'h1: y = 4'h4;
      4'h2: y = 4'hB;
      4'h3: y = 4'h1;
      4'h4: y = 4'h7;
      4'h5: y = 4'h9;
      4'h6: y = 4'hC;
      4'h7: y = 4'hA;
      4'h8: y = 4'hD;
      4'h9: y = 4'h2;
      4'hA: y = 4'h0;
      4'hB: y = 4'hF;
      4'hC: y = 4'h8;
      4'hD: y = 4'h5;
      4'hE: y = 4'h3;
      default: y = 4'h6;
    endcase
    return y;
  endfunction

  function automatic logic [15:0] rotl16(input logic [15:0] w, input int unsigned n);
    return (w << n) | (w >> (16 - n));
  endfunction

endpackage

// File: rtl/boron_round_fn.sv
// One combinational BORON round: key add, S-layer, byte shuffle, rotations, word XOR.
module boron_round_fn
  import boron_pkg::*;
(
  input  logic [63:0] d,
  input  logic [63:0] rk,
  output logic [63:0] d_next
);

  logic [63:0] ark;
  logic [63:0] sl;
  logic [63:0] sh;
  logic [15:0] w0, w1, w2, w3;

  always_comb begin
    ark = d ^ rk;
    sl  = '0;
    sh  = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      sl[4*i +: 4] = sbox(ark[4*i +: 4]);
    end
    for (int unsigned i = 0; i < 8; i++) begin
      sh[8*i +: 8] = sl[8*BYTE_SRC[3*i +: 3] +: 8];
    end
    w0 = rotl16(sh[15:0],  ROT_W0);
    w1 = rotl16(sh[31:16], ROT_W1);
    w2 = rotl16(sh[47:32], ROT_W2);
    w3 = rotl16(sh[63:48], ROT_W3);
    // W2 takes the already-updated W1; W3 uses W0, which never changes.
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w0;
    d_next = {w3, w2, w1, w0};
  end

endmodule

// File: rtl/boron_round.sv
// Iterative BORON encryption: one round per clock, 25 rounds then key whitening.
module boron_round
  import boron_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] plain_text,
  input  logic [79:0] key,
  output logic [63:0] cipher_text,
  output logic        done
);

  localparam logic [4:0] LAST = 5'(NUM_ROUNDS);

  logic [63:0] d, d_next;
  logic [79:0] k, k_rot, k_next;
  logic [4:0]  cnt;

  boron_round_fn u_round_fn (
    .d      (d),
    .rk     (k[63:0]),
    .d_next (d_next)
  );

  always_comb begin
    k_rot         = {k[79-KEY_ROT:0], k[79:80-KEY_ROT]};
    k_next        = k_rot;
    k_next[3:0]   = sbox(k_rot[3:0]);
    k_next[63:59] = k_rot[63:59] ^ (cnt + 5'd1);
  end

  // Reset loads the operands, so round 1 runs on the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d           <= plain_text;
      k           <= key;
      cnt         <= '0;
      done        <= 1'b0;
      cipher_text <= '0;
    end else if (cnt < LAST) begin
      d   <= d_next;
      k   <= k_next;
      cnt <= cnt + 5'd1;
    end else if (cnt == LAST) begin
      cipher_text <= d ^ k[63:0];
      done        <= 1'b1;
      cnt         <= cnt + 5'd1;
    end
  end

endmodule

// File: tb/tb_boron_round.sv
// Self-checking bench for boron_round with a scoreboard of model ciphertexts.
module tb_boron_round;

  logic        clk;
  logic        rst;
  logic [63:0] plain_text;
  logic [79:0] key;
  logic [63:0] cipher_text;
  logic        done;

  int n_vec;
  int n_err;
  logic [63:0] sb[$];
  logic [63:0] m_d1;
  logic [79:0] m_k1;

  boron_round dut (
    .clk         (clk),
    .rst         (rst),
    .plain_text  (plain_text),
    .key         (key),
    .cipher_text (cipher_text),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] m_sbox(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h6358_F02D_AC97_1B4E;
    return t[4*x +: 4];
  endfunction

  function automatic logic [63:0] m_round(input logic [63:0] d, input logic [63:0] rk);
    logic [63:0] a, s, h;
    logic [15:0] x0, x1, x2, x3;
    a = d ^ rk;
    s = '0;
    for (int n = 0; n < 16; n++) s[4*n +: 4] = m_sbox(a[4*n +: 4]);
    h = {s[47:40], s[39:32], s[63:56], s[55:48], s[15:8], s[7:0], s[31:24], s[23:16]};
    x0 = {h[14:0],  h[15]};
    x1 = {h[27:16], h[31:28]};
    x2 = {h[40:32], h[47:41]};
    x3 = {h[54:48], h[63:55]};
    x1 = x1 ^ x0;
    x2 = x2 ^ x1;
    x3 = x3 ^ x0;
    return {x3, x2, x1, x0};
  endfunction

  function automatic logic [79:0] m_key(input logic [79:0] k, input int r);
    logic [79:0] q;
    logic [4:0]  rr;
    rr = 5'(r);
    q = {k[66:0], k[79:67]};
    q[3:0] = m_sbox(q[3:0]);
    q[63:59] = q[63:59] ^ rr;
    return q;
  endfunction

  task automatic model(input logic [63:0] pt, input logic [79:0] kk,
                       output logic [63:0] c, output logic [63:0] d1, output logic [79:0] k1);
    logic [63:0] dd;
    logic [79:0] ck;
    dd = pt;
    ck = kk;
    d1 = '0;
    k1 = '0;
    for (int r = 1; r <= 25; r++) begin
      dd = m_round(dd, ck[63:0]);
      ck = m_key(ck, r);
      if (r == 1) begin
        d1 = dd;
        k1 = ck;
      end
    end
    c = dd ^ ck[63:0];
  endtask

  // Reset with the operands applied, push the expected result, release.
  task automatic start_op(input logic [63:0] pt, input logic [79:0] kk);
    logic [63:0] c;
    @(negedge clk);
    plain_text = pt;
    key = kk;
    rst = 1'b0;
    model(pt, kk, c, m_d1, m_k1);
    sb.push_back(c);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_done(input int start, output int edges);
    edges = start;
    while (edges < 40) begin
      @(posedge clk);
      edges++;
      #1;
      if (done) return;
    end
    edges = -1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b0;
    plain_text = {$urandom, $urandom};
    key = {16'($urandom), $urandom, $urandom};
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_done got=%b want=0", done);
    end
    n_vec++;
    if (cipher_text !== 64'h0) begin
      n_err++;
      $display("FAIL reset_cipher got=%h want=0", cipher_text);
    end
  endtask

  task automatic test_latency;
    int e;
    logic [63:0] exp;
    start_op(64'h0, 80'h0);
    wait_done(0, e);
    n_vec++;
    if (e !== 26) begin
      n_err++;
      $display("FAIL latency got=%0d want=26", e);
    end
    exp = sb.pop_front();
    n_vec++;
    if (cipher_text !== exp) begin
      n_err++;
      $display("FAIL latency_cipher got=%h want=%h", cipher_text, exp);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if (cipher_text !== exp || done !== 1'b1) begin
        n_err++;
        $display("FAIL hold_%0d got=%h/%b want=%h/1", i, cipher_text, done, exp);
      end
    end
  endtask

  task automatic test_kat(input logic [63:0] pt, input logic [79:0] kk);
    int e;
    logic [63:0] exp;
    start_op(pt, kk);
    @(posedge clk);
    #1;
    n_vec++;
    if (dut.d !== m_d1) begin
      n_err++;
      $display("FAIL kat_d1 got=%h want=%h", dut.d, m_d1);
    end
    n_vec++;
    if (dut.k !== m_k1) begin
      n_err++;
      $display("FAIL kat_k1 got=%h want=%h", dut.k, m_k1);
    end
    wait_done(1, e);
    n_vec++;
    if (e !== 26) begin
      n_err++;
      $display("FAIL kat_latency got=%0d want=26", e);
    end
    exp = sb.pop_front();
    n_vec++;
    if (cipher_text !== exp) begin
      n_err++;
      $display("FAIL kat_cipher pt=%h got=%h want=%h", pt, cipher_text, exp);
    end
  endtask

  task automatic test_key_sbox;
    int e;
    logic [63:0] exp;
    start_op(64'h0123_4567_89AB_CDEF, 80'h0);
    @(posedge clk);
    #1;
    n_vec++;
    if (dut.k[63:59] !== 5'h01) begin
      n_err++;
      $display("FAIL key_rc got=%h want=01", dut.k[63:59]);
    end
    n_vec++;
    if (dut.k[3:0] !== 4'hE) begin
      n_err++;
      $display("FAIL key_sbox got=%h want=e", dut.k[3:0]);
    end
    wait_done(1, e);
    exp = sb.pop_front();
    n_vec++;
    if (cipher_text !== exp) begin
      n_err++;
      $display("FAIL key_sbox_cipher got=%h want=%h", cipher_text, exp);
    end
  endtask

  task automatic test_abort;
    int e;
    logic [63:0] c, exp;
    start_op(64'hDEAD_BEEF_0BAD_F00D, 80'h1234_5678_9ABC_DEF0_1357);
    repeat (12) @(posedge clk);
    @(negedge clk);
    void'(sb.pop_back());
    plain_text = 64'h0F1E_2D3C_4B5A_6978;
    key = 80'hA5A5_5A5A_C3C3_3C3C_9696;
    rst = 1'b0;
    model(plain_text, key, c, m_d1, m_k1);
    sb.push_back(c);
    #1;
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_done got=%b want=0", done);
    end
    @(negedge clk);
    rst = 1'b1;
    wait_done(0, e);
    n_vec++;
    if (e !== 26) begin
      n_err++;
      $display("FAIL abort_latency got=%0d want=26", e);
    end
    exp = sb.pop_front();
    n_vec++;
    if (cipher_text !== exp) begin
      n_err++;
      $display("FAIL abort_cipher got=%h want=%h", cipher_text, exp);
    end
  endtask

  task automatic test_freeze_and_async;
    int e;
    logic [63:0] exp;
    start_op(64'h5555_AAAA_3333_CCCC, 80'hFEDC_BA98_7654_3210_0F0F);
    wait_done(0, e);
    exp = sb.pop_front();
    @(negedge clk);
    plain_text = ~plain_text;
    key = ~key;
    repeat (5) @(negedge clk);
    n_vec++;
    if (cipher_text !== exp || done !== 1'b1) begin
      n_err++;
      $display("FAIL freeze got=%h/%b want=%h/1", cipher_text, done, exp);
    end
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    n_vec++;
    if (done !== 1'b0 || cipher_text !== 64'h0) begin
      n_err++;
      $display("FAIL async_reset got=%h/%b want=0/0", cipher_text, done);
    end
  endtask

  task automatic test_back_to_back;
    int e;
    logic [63:0] exp;
    for (int i = 0; i < 3; i++) begin
      start_op({$urandom, $urandom}, {16'($urandom), $urandom, $urandom});
      wait_done(0, e);
      exp = sb.pop_front();
      n_vec++;
      if (e !== 26 || cipher_text !== exp) begin
        n_err++;
        $display("FAIL b2b_%0d edges=%0d got=%h want=%h", i, e, cipher_text, exp);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    plain_text = '0;
    key = '0;
    test_reset();
    test_latency();
    test_kat(64'hFFFF_FFFF_FFFF_FFFF, 80'hFFFF_FFFF_FFFF_FFFF_FFFF);
    test_kat(64'h0123_4567_89AB_CDEF, 80'h0000_1111_2222_3333_4444);
    test_key_sbox();
    test_abort();
    test_freeze_and_async();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
